// File: rtl/complex_accumulator.sv
// Sums ACC_LEN complex products per frame with per-part saturation; result registered 1 cycle after last accept.
// Backpressure: result held while OutReady is low; no product accepted until the result handshake completes.
module complex_accumulator #(
    parameter int ACC_LEN = 8,
    parameter int ACC_W   = 24
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    InValid,
    output logic                    InReady,
    input  logic [33:0]             InProduct,
    output logic                    OutValid,
    input  logic                    OutReady,
    output logic signed [ACC_W-1:0] OutReal,
    output logic signed [ACC_W-1:0] OutImag,
    output logic                    Overflow
);
    localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ACC_LEN - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        count;
    logic signed [ACC_W-1:0] acc_re;
    logic signed [ACC_W-1:0] acc_im;
    logic                    ovf_sticky;
    logic signed [ACC_W-1:0] sum_re;
    logic signed [ACC_W-1:0] sum_im;
    logic                    ovf_re;
    logic                    ovf_im;

    // Returns {saturated, value}; one guard bit is enough to detect overflow of a single add.
    function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] a,
                                               input logic [16:0] b);
        logic signed [ACC_W:0] s;
        s = $signed({a[ACC_W-1], a}) + $signed({{(ACC_W-16){b[16]}}, b});
        if (s[ACC_W] != s[ACC_W-1])
            return {1'b1, s[ACC_W] ? SAT_MIN : SAT_MAX};
        return {1'b0, s[ACC_W-1:0]};
    endfunction

    always_comb begin
        {ovf_re, sum_re} = sat_add(acc_re, InProduct[33:17]);
        {ovf_im, sum_im} = sat_add(acc_im, InProduct[16:0]);
    end

    assign InReady = (state == ACCUM);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= ACCUM;
            count      <= '0;
            acc_re     <= '0;
            acc_im     <= '0;
            ovf_sticky <= 1'b0;
            OutValid   <= 1'b0;
            OutReal    <= '0;
            OutImag    <= '0;
            Overflow   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (InValid) begin
                        if (count == LAST) begin
                            OutReal    <= sum_re;
                            OutImag    <= sum_im;
                            Overflow   <= ovf_sticky | ovf_re | ovf_im;
                            OutValid   <= 1'b1;
                            acc_re     <= '0;
                            acc_im     <= '0;
                            ovf_sticky <= 1'b0;
                            count      <= '0;
                            state      <= HOLD;
                        end else begin
                            acc_re     <= sum_re;
                            acc_im     <= sum_im;
                            ovf_sticky <= ovf_sticky | ovf_re | ovf_im;
                            count      <= count + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (OutReady) begin
                        OutValid <= 1'b0;
                        state    <= ACCUM;
                    end
                end
            endcase
        end
    end
endmodule
